// File: rtl/shift_feeder.sv
// shift_feeder: turns LOAD/ROTATE commands into s_in/en/dir/rot for a serial shift/rotate register.
// Latency: en starts the cycle after accept, done pulses one cycle after the final en; all outputs registered.
// Backpressure: cmd_ready low from the accept edge until back in IDLE; SHIFT_FEEDER_PACE_EN spaces en PACE apart.
module shift_feeder #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
`ifdef SHIFT_FEEDER_PACE_EN
    , parameter int PACE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    output logic             s_in,
    output logic             en,
    output logic             dir,
    output logic             rot,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, ROT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dat_q;
    logic [CW-1:0]    bit_cnt;
    logic [AMT_W-1:0] rot_left;
    logic             last_step;
    logic             step;

    assign last_step = (state == LOAD) ? (bit_cnt == CW'(WIDTH - 1)) : (rot_left == '0);

`ifdef SHIFT_FEEDER_PACE_EN
    localparam int PW = (PACE > 2) ? $clog2(PACE) : 1;
    logic [PW-1:0] pace_cnt;
    // Next en is due either immediately (PACE==1) or once the idle gap has counted out.
    assign step = (en && (PACE == 1)) || (!en && (pace_cnt == '0));
`else
    assign step = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            s_in      <= 1'b0;
            en        <= 1'b0;
            dir       <= 1'b0;
            rot       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dat_q     <= '0;
            bit_cnt   <= '0;
            rot_left  <= '0;
`ifdef SHIFT_FEEDER_PACE_EN
            pace_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        dir       <= cmd_dir;
                        bit_cnt   <= '0;
                        if (!cmd_op) begin
                            state <= LOAD;
                            en    <= 1'b1;
                            rot   <= 1'b0;
                            // Present the first bit now; dat_q keeps the remaining bits queued at its edge.
                            s_in  <= cmd_dir ? cmd_data[WIDTH-1] : cmd_data[0];
                            dat_q <= cmd_dir ? (cmd_data << 1) : (cmd_data >> 1);
                        end else if (cmd_amt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ROT;
                            en       <= 1'b1;
                            rot      <= 1'b1;
                            s_in     <= 1'b0;
                            rot_left <= cmd_amt - 1'b1;
                        end
                    end
                end
                LOAD, ROT: begin
                    if (en && last_step) begin
                        state <= DONE;
                        en    <= 1'b0;
                        rot   <= 1'b0;
                        done  <= 1'b1;
                    end else if (step) begin
                        en <= 1'b1;
                        if (state == LOAD) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            s_in    <= dir ? dat_q[WIDTH-1] : dat_q[0];
                            dat_q   <= dir ? (dat_q << 1) : (dat_q >> 1);
                        end else begin
                            rot_left <= rot_left - 1'b1;
                        end
`ifdef SHIFT_FEEDER_PACE_EN
                    end else if (en) begin
                        en       <= 1'b0;
                        pace_cnt <= PW'(PACE - 2);
                    end else begin
                        pace_cnt <= pace_cnt - 1'b1;
`endif
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_feeder.sv
// tb_shift_feeder: directed commands, a cycle-indexed expectation model and a downstream register model.
// Outputs are compared every cycle on the falling edge; inputs change #1 after the rising edge.
module tb_shift_feeder;
    localparam int W = 4;
`ifdef SHIFT_FEEDER_PACE_EN
    localparam int P       = 3;
    localparam int D_LOAD  = 11;
    localparam int D_ROT3  = 8;
    localparam int D_ROT6  = 17;
    localparam int BP_GAP  = 12;
`else
    localparam int P       = 1;
    localparam int D_LOAD  = 5;
    localparam int D_ROT3  = 4;
    localparam int D_ROT6  = 7;
    localparam int BP_GAP  = 6;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_op, cmd_dir;
    logic [W-1:0] cmd_data;
    logic [2:0] cmd_amt;
    logic       s_in, en, dir, rot, busy, done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    shift_feeder #(
        .WIDTH(W),
        .AMT_W(3)
`ifdef SHIFT_FEEDER_PACE_EN
        , .PACE(P)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dir(cmd_dir), .cmd_data(cmd_data), .cmd_amt(cmd_amt),
        .s_in(s_in), .en(en), .dir(dir), .rot(rot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Downstream shift/rotate register as the feeder's consumer sees it.
    logic [W-1:0] sreg = '0;
    always @(posedge clk) begin
        if (en) begin
            if (rot) sreg <= dir ? {sreg[W-2:0], sreg[W-1]} : {sreg[0], sreg[W-1:1]};
            else     sreg <= dir ? {sreg[W-2:0], s_in}      : {s_in, sreg[W-1:1]};
        end
    end

    // Expectation model: k = cycles since accept (-1 when idle); outputs follow from k alone.
    int k = -1;
    int m_n, m_done, j;
    bit m_op;
    logic [W-1:0] m_data;
    logic e_ready, e_en, e_rot, e_busy, e_done, e_sin, e_dir;
    always @(posedge clk) begin
        if (rst) begin
            k = -1; e_sin = 1'b0; e_dir = 1'b0;
        end else begin
            if (k >= 0) begin
                k++;
                if (k > m_done) k = -1;
            end else if (cmd_valid) begin
                m_op   = cmd_op;
                m_data = cmd_data;
                e_dir  = cmd_dir;
                m_n    = cmd_op ? int'(cmd_amt) : W;
                m_done = (m_n == 0) ? 1 : (m_n - 1) * P + 2;
                k      = 1;
            end
            if (k >= 1 && k < m_done) begin
                j = (k - 1) / P;
                if (m_op) e_sin = 1'b0;
                else      e_sin = e_dir ? m_data[W-1-j] : m_data[j];
            end
        end
        e_en    = (k >= 1) && (k < m_done) && (((k - 1) % P) == 0);
        e_rot   = m_op && (k >= 1) && (k < m_done);
        e_busy  = (k >= 1);
        e_done  = (k >= 1) && (k == m_done);
        e_ready = (k < 0);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            tests++;
            if ({cmd_ready, en, rot, busy, done, s_in, dir} !==
                {e_ready, e_en, e_rot, e_busy, e_done, e_sin, e_dir}) begin
                fails++;
                $display("FAIL cycle %0d outputs rdy/en/rot/busy/done/sin/dir: got %b required %b", cyc,
                         {cmd_ready, en, rot, busy, done, s_in, dir},
                         {e_ready, e_en, e_rot, e_busy, e_done, e_sin, e_dir});
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Waits (bounded) for a falling edge with cmd_ready high; returns the cycle number or -1.
    task automatic wait_ready(output int at);
        at = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin at = cyc; break; end
        end
        if (at < 0) chk("wait_ready timeout", 0, 1);
    endtask

    task automatic run(input bit op, input bit d, input logic [W-1:0] data, input logic [2:0] amt,
                       input int x_en, input logic [7:0] x_seq, input int x_done,
                       input logic [W-1:0] x_reg, input string nm);
        int acc, en_n, busy_n, done_at;
        logic [7:0] seq;
        en_n = 0; busy_n = 0; done_at = -1; seq = '0;
        @(posedge clk); #1;
        cmd_op = op; cmd_dir = d; cmd_data = data; cmd_amt = amt; cmd_valid = 1'b1;
        wait_ready(acc);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~op; cmd_dir = ~d; cmd_data = ~data; cmd_amt = amt + 3'd1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (en) begin en_n++; seq = {seq[6:0], s_in}; end
            if (busy) busy_n++;
            if (done) begin done_at = i; break; end
        end
        chk({nm, " en count"}, en_n, x_en);
        chk({nm, " s_in sequence"}, seq, x_seq);
        chk({nm, " done offset"}, done_at, x_done);
        chk({nm, " busy cycles"}, busy_n, x_done);
        chk({nm, " register"}, sreg, x_reg);
    endtask

    initial begin
        int a1, a2, en_n, done_n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_dir = 1'b0; cmd_data = '0; cmd_amt = '0;
        @(posedge clk); chk_on = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset busy", busy, 0);

        run(1'b0, 1'b1, 4'b1011, 3'd0, 4, 8'b0000_1011, D_LOAD, 4'b1011, "load left 1011");

        // Reset while idle must clear the held s_in/dir left by the last LOAD.
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle reset s_in", s_in, 0);
        chk("idle reset dir", dir, 0);
        chk("idle reset cmd_ready", cmd_ready, 1);

        run(1'b0, 1'b0, 4'b1100, 3'd0, 4, 8'b0000_0011, D_LOAD, 4'b1100, "load right 1100");
        run(1'b0, 1'b1, 4'b1000, 3'd0, 4, 8'b0000_1000, D_LOAD, 4'b1000, "load left 1000");
        run(1'b1, 1'b1, 4'b1111, 3'd3, 3, 8'h00, D_ROT3, 4'b0100, "rotate left 3");
        run(1'b1, 1'b1, 4'b1111, 3'd0, 0, 8'h00, 1, 4'b0100, "rotate 0");
        run(1'b1, 1'b0, 4'b0000, 3'd6, 6, 8'h00, D_ROT6, 4'b0001, "rotate right 6");
        run(1'b0, 1'b1, 4'b0110, 3'd0, 4, 8'b0000_0110, D_LOAD, 4'b0110, "load left 0110");

        // cmd_valid held high: the second command waits for cmd_ready and its new fields must not leak into the first.
        @(posedge clk); #1;
        cmd_op = 1'b0; cmd_dir = 1'b1; cmd_data = 4'b1010; cmd_valid = 1'b1;
        wait_ready(a1);
        @(posedge clk); #1;
        cmd_dir = 1'b0; cmd_data = 4'b0101;
        wait_ready(a2);
        chk("backpressure accept spacing", a2 - a1, BP_GAP);
        @(posedge clk); #1 cmd_valid = 1'b0;
        wait_ready(a1);
        chk("backpressure second register", sreg, 4'b0101);

        // Abort on the 2nd en cycle of a LOAD.
        @(posedge clk); #1;
        cmd_op = 1'b0; cmd_dir = 1'b1; cmd_data = 4'b1111; cmd_valid = 1'b1;
        wait_ready(a1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        en_n = 0;
        for (int i = 0; i < 40 && en_n < 2; i++) begin
            @(negedge clk);
            if (en) en_n++;
        end
        chk("abort reached 2nd en", en_n, 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort en", en, 0);
        chk("abort cmd_ready", cmd_ready, 1);
        done_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        chk("abort no done", done_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
